// File: rtl/serial_deser.sv
`default_nettype none
// ============================================================================
// Module      : serial_deser
// Description : Serial-to-parallel deserializer with sync-framed input,
//               valid/ready holding register and sticky error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_deser #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit CONTINUOUS = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     din,
    input  logic                     din_en,
    input  logic                     sync,
    input  logic                     dout_ready,
    input  logic                     clr_err,
    output logic [WIDTH-1:0]         dout,
    output logic                     dout_valid,
    output logic                     overrun,
    output logic                     frame_err,
    output logic [$clog2(WIDTH)-1:0] bit_cnt
);

    localparam int              CW         = $clog2(WIDTH);
    localparam logic [CW-1:0]   c_last_bit = CW'(WIDTH - 1);
    localparam logic [0:0]      c_st_idle  = 1'b0;
    localparam logic [0:0]      c_st_shift = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovr_q, ovr_d;
    logic             ferr_q, ferr_d;

    logic             w_take;
    logic             w_resync;
    logic             w_complete;
    logic             w_load;
    logic [CW-1:0]    w_base_cnt;
    logic [WIDTH-1:0] w_base_sr;
    logic [WIDTH-1:0] w_shifted;

    // A qualified sync always opens a fresh frame, so the partial word and
    // its count are replaced by zero before the incoming bit is shifted in.
    always_comb begin
        w_take     = din_en && (sync || (state_q == c_st_shift));
        w_base_cnt = sync ? '0 : cnt_q;
        w_base_sr  = sync ? '0 : sr_q;
        w_complete = w_take && (w_base_cnt == c_last_bit);
        w_resync   = din_en && sync && (state_q == c_st_shift) && (cnt_q != '0);
        w_load     = w_complete && (!valid_q || dout_ready);
    end

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shifted = (w_base_sr << 1) | WIDTH'(din);
        end else begin : g_lsb_first
            assign w_shifted = (w_base_sr >> 1) | {din, {(WIDTH-1){1'b0}}};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        if (w_take) begin
            sr_d = w_shifted;
            if (w_complete) begin
                cnt_d   = '0;
                state_d = CONTINUOUS ? c_st_shift : c_st_idle;
            end else begin
                cnt_d   = w_base_cnt + CW'(1);
                state_d = c_st_shift;
            end
        end
        // Load and handshake in one cycle keep valid high with the new word.
        if (w_load) begin
            dout_d  = w_shifted;
            valid_d = 1'b1;
        end else if (valid_q && dout_ready) begin
            valid_d = 1'b0;
        end
        ovr_d  = (w_complete && !w_load) || (ovr_q && !clr_err);
        ferr_d = w_resync || (ferr_q && !clr_err);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_st_idle;
            sr_q    <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign overrun    = ovr_q;
    assign frame_err  = ferr_q;
    assign bit_cnt    = cnt_q;

endmodule
`default_nettype wire
